// File: rtl/add_serial_nbit.sv
// add_serial_nbit: digit-serial add/subtract with carry/overflow/zero flags and start/busy/done handshake
module add_serial_nbit #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW = NDIG > 1 ? $clog2(NDIG) : 1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, sum_q, sum_d, res;
  logic [KW-1:0] k_q, k_d;
  logic sub_q, sub_d, sm_q, sm_d, c_q, c_d, am_q, am_d, bm_q, bm_d;
  logic carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [DIGIT:0] dsum;
  logic [WIDTH+DIGIT-1:0] cat;
  logic accept, last;
  assign accept = start && state_q != S_RUN;
  assign last = state_q == S_RUN && k_q == KW'(NDIG - 1);
  assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0] ^ {DIGIT{sub_q}}} + (DIGIT+1)'(c_q);
  // new digit enters at the top; after NDIG shifts the register holds the whole result
  assign cat = {dsum[DIGIT-1:0], sh_q};
  assign res = cat[WIDTH+DIGIT-1:DIGIT];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = accept ? S_RUN : last ? S_FIN : state_q == S_FIN ? S_IDLE : state_q;
  end
  always_comb begin
    busy = state_q == S_RUN;
    done = state_q == S_FIN;
  end
  always_comb begin
    a_d = accept ? a : busy ? a_q >> DIGIT : a_q;
    b_d = accept ? b : busy ? b_q >> DIGIT : b_q;
    sub_d = accept ? sub : sub_q;
    sm_d = accept ? signed_mode : sm_q;
    am_d = accept ? a[WIDTH-1] : am_q;
    bm_d = accept ? b[WIDTH-1] ^ sub : bm_q;
    c_d = accept ? sub : busy ? dsum[DIGIT] : c_q;
    k_d = accept ? '0 : busy ? k_q + 1'b1 : k_q;
    sh_d = busy ? res : sh_q;
    sum_d = last ? res : sum_q;
    carry_d = last ? dsum[DIGIT] : carry_q;
    ovf_d = last ? (sm_q ? (am_q == bm_q) && (res[WIDTH-1] != am_q) : dsum[DIGIT] ^ sub_q) : ovf_q;
    zero_d = last ? res == '0 : zero_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      sub_q <= 1'b0;
      sm_q <= 1'b0;
      am_q <= 1'b0;
      bm_q <= 1'b0;
      c_q <= 1'b0;
      k_q <= '0;
      sh_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      sub_q <= sub_d;
      sm_q <= sm_d;
      am_q <= am_d;
      bm_q <= bm_d;
      c_q <= c_d;
      k_q <= k_d;
      sh_q <= sh_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
    end
  end
  assign sum = sum_q;
  assign carry = carry_q;
  assign overflow = ovf_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_add_serial_nbit.sv
// tb_add_serial_nbit: scoreboard bench for the serial adder at WIDTH=16 and WIDTH=4
module tb_add_serial_nbit;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic st16 = 0, sub16 = 0, sm16 = 0, busy16, done16, c16, ov16, z16;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic st4 = 0, sub4 = 0, sm4 = 0, busy4, done4, c4, ov4, z4;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  typedef struct packed {logic [15:0] sum; logic c; logic ov; logic z;} exp_t;
  exp_t q16[$], q4[$];
  int errors = 0, checks = 0, lat, seen;

  add_serial_nbit #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .reset(reset), .start(st16), .a(a16), .b(b16), .sub(sub16), .signed_mode(sm16),
    .busy(busy16), .done(done16), .sum(sum16), .carry(c16), .overflow(ov16), .zero(z16));
  add_serial_nbit #(.WIDTH(4), .DIGIT(4)) u4 (
    .clk(clk), .reset(reset), .start(st4), .a(a4), .b(b4), .sub(sub4), .signed_mode(sm4),
    .busy(busy4), .done(done4), .sum(sum4), .carry(c4), .overflow(ov4), .zero(z4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: integer arithmetic on the mathematical values, then range tests
  function automatic exp_t model(input int w, input int a, input int b, input bit sub, input bit sm);
    exp_t e;
    int m, r, sa, sb, rs;
    m = 1 << w;
    a = a % m;
    b = b % m;
    r = sub ? a - b : a + b;
    r = r < 0 ? r + m : r >= m ? r - m : r;
    sa = a >= m / 2 ? a - m : a;
    sb = b >= m / 2 ? b - m : b;
    rs = sub ? sa - sb : sa + sb;
    e.sum = 16'(r);
    e.c = sub ? a >= b : a + b >= m;
    e.ov = sm ? (rs < -m / 2 || rs >= m / 2) : (sub ? a < b : a + b >= m);
    e.z = r == 0;
    return e;
  endfunction

  always @(negedge clk) if (!reset && done16) begin
    exp_t e;
    if (q16.size() == 0) chk("done16_unexpected", 1, 0);
    else begin
      e = q16.pop_front();
      chk("sum16", 32'(sum16), 32'(e.sum));
      chk("carry16", 32'(c16), 32'(e.c));
      chk("ovf16", 32'(ov16), 32'(e.ov));
      chk("zero16", 32'(z16), 32'(e.z));
    end
  end

  always @(negedge clk) if (!reset && done4) begin
    exp_t e;
    if (q4.size() == 0) chk("done4_unexpected", 1, 0);
    else begin
      e = q4.pop_front();
      chk("sum4", 32'(sum4), 32'(e.sum));
      chk("carry4", 32'(c4), 32'(e.c));
      chk("ovf4", 32'(ov4), 32'(e.ov));
      chk("zero4", 32'(z4), 32'(e.z));
    end
  end

  task automatic issue(input bit w4, input int a, input int b, input bit sub, input bit sm);
    if (w4) begin
      a4 = 4'(a); b4 = 4'(b); sub4 = sub; sm4 = sm; st4 = 1;
      q4.push_back(model(4, a, b, sub, sm));
    end else begin
      a16 = 16'(a); b16 = 16'(b); sub16 = sub; sm16 = sm; st16 = 1;
      q16.push_back(model(16, a, b, sub, sm));
    end
  endtask

  task automatic run(input bit w4, input int a, input int b, input bit sub, input bit sm, output int n);
    issue(w4, a, b, sub, sm);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      st4 = 0;
      st16 = 0;
      if (w4 ? done4 : done16) break;
    end
    if (!(w4 ? done4 : done16)) chk("done_timeout", 0, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy16), 0);
    chk("rst_done", 32'(done16), 0);
    chk("rst_sum", 32'(sum16), 0);
    chk("rst_flags", 32'({c16, ov16, z16}), 0);
    reset = 0;
    @(negedge clk);
    run(0, 'hFFFF, 'h0001, 0, 0, lat);
    chk("lat16", lat, 5);
    chk("t1_sum", 32'(sum16), 0);
    chk("t1_flags", 32'({c16, ov16, z16}), 32'b111);
    run(0, 'h7FFF, 'h0001, 0, 1, lat);
    chk("t2_sum", 32'(sum16), 'h8000);
    chk("t2_flags", 32'({c16, ov16}), 32'b01);
    run(0, 'hFFFF, 'h0001, 0, 1, lat);
    run(0, 'h0003, 'h0005, 1, 0, lat);
    chk("t3_sum", 32'(sum16), 'hFFFE);
    chk("t3_flags", 32'({c16, ov16}), 32'b01);
    run(0, 'h0003, 'h0005, 1, 1, lat);
    run(0, 'h1234, 'h1234, 1, 0, lat);
    run(0, 'h1111, 'h2222, 0, 0, lat);
    issue(0, 'h0101, 'h0202, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom); st16 = 1;
      chk("busy_run", 32'(busy16), 1);
      chk("sum_hold", 32'(sum16), 'h3333);
    end
    @(negedge clk);
    st16 = 0;
    for (int i = 0; i < 10 && !done16; i++) @(negedge clk);
    chk("t4_done", 32'(done16), 1);
    chk("t4_sum", 32'(sum16), 'h0303);
    run(0, 'h00FF, 'h0001, 1, 0, lat);
    chk("b2b_lat", lat, 5);
    issue(0, 'h1000, 'h2000, 0, 0);
    repeat (2) @(negedge clk);
    st16 = 0;
    reset = 1;
    q16.delete();
    #1;
    chk("abort_busy", 32'(busy16), 0);
    chk("abort_done", 32'(done16), 0);
    chk("abort_sum", 32'(sum16), 0);
    chk("abort_flags", 32'({c16, ov16, z16}), 0);
    @(negedge clk);
    reset = 0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen += int'(done16);
    end
    chk("abort_no_done", seen, 0);
    run(0, 'h1234, 'h4321, 0, 0, lat);
    chk("post_rst_sum", 32'(sum16), 'h5555);
    run(1, 9, 8, 0, 0, lat);
    chk("lat4", lat, 2);
    chk("w4_sum", 32'(sum4), 1);
    chk("w4_carry", 32'(c4), 1);
    for (int m = 0; m < 2; m++)
      repeat (1000) begin
        run(0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 1'($urandom), 1'(m), lat);
        if (lat != 5) chk("rand_lat16", lat, 5);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
    repeat (300) begin
      run(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), lat);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("q16_drained", q16.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
